// File: rtl/rst_sequencer.sv
// rst_sequencer: timed active-low design reset with a debounced manual-reset
// pushbutton and a clock-enable strobe for slow logic on the single clock.
//
// Ports:
//   clk     in   design clock
//   reset   in   synchronous active-high reset, overrides everything
//   btn_i   in   raw pushbutton (asynchronous, bouncy)
//   resetn  out  timed active-low reset, registered
//   ce_o    out  one-cycle enable every DIV cycles while resetn=1, registered
module rst_sequencer #(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DIV             = 4,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic resetn,
  output logic ce_o
);

  localparam int HW = (HOLD_CYCLES     > 1) ? $clog2(HOLD_CYCLES)     : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int VW = (DIV             > 1) ? $clog2(DIV)             : 1;

  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [VW-1:0] DIV_MAX  = VW'(DIV - 1);

  // Raw button level that means "not pressed".
  localparam logic NOT_PRESSED = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] S_HOLD         = 2'd0;
  localparam logic [1:0] S_RUN          = 2'd1;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd2;

  logic [1:0]    r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [VW-1:0] r_div_cnt;

  logic          w_pressed;
  logic          w_db_next;
  logic [DW-1:0] w_db_cnt_next;

  assign w_pressed = (r_sync2 != NOT_PRESSED);

  always_comb begin
    w_db_next     = r_db;
    w_db_cnt_next = '0;
    if (w_pressed != r_db) begin
      if (r_db_cnt == DB_MAX) begin
        w_db_next = ~r_db;
      end else begin
        w_db_cnt_next = r_db_cnt + 1'b1;
      end
    end
  end

  // The FSM acts on the debounced value being written this edge, so resetn
  // follows the debounced state on the same edge (2 + DEBOUNCE_CYCLES latency).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_HOLD;
      r_sync1    <= NOT_PRESSED;
      r_sync2    <= NOT_PRESSED;
      r_db       <= 1'b0;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_div_cnt  <= '0;
      resetn     <= 1'b0;
      ce_o       <= 1'b0;
    end else begin
      r_sync1  <= btn_i;
      r_sync2  <= r_sync1;
      r_db     <= w_db_next;
      r_db_cnt <= w_db_cnt_next;

      case (r_state)
        S_HOLD: begin
          resetn    <= 1'b0;
          ce_o      <= 1'b0;
          r_div_cnt <= '0;
          if (w_db_next) begin
            r_state    <= S_WAIT_RELEASE;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_MAX) begin
            r_state    <= S_RUN;
            r_hold_cnt <= '0;
            resetn     <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (w_db_next) begin
            r_state   <= S_WAIT_RELEASE;
            resetn    <= 1'b0;
            ce_o      <= 1'b0;
            r_div_cnt <= '0;
          end else begin
            resetn <= 1'b1;
            if (r_div_cnt == DIV_MAX) begin
              r_div_cnt <= '0;
              ce_o      <= 1'b1;
            end else begin
              r_div_cnt <= r_div_cnt + 1'b1;
              ce_o      <= 1'b0;
            end
          end
        end

        S_WAIT_RELEASE: begin
          resetn    <= 1'b0;
          ce_o      <= 1'b0;
          r_div_cnt <= '0;
          if (!w_db_next) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end
        end

        default: begin
          r_state    <= S_HOLD;
          r_hold_cnt <= '0;
          r_div_cnt  <= '0;
          resetn     <= 1'b0;
          ce_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: self-checking bench for rst_sequencer.
// Two instances share clk/reset/btn_i: dut (HOLD=4, DEB=3, DIV=3) and
// dut2 (HOLD=1, DEB=3, DIV=1). Every cycle both are compared against a
// behavioural model; table vectors and hand sequences add explicit checks.
module tb_rst_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b1;
  logic resetn1, ce1, resetn2, ce2;

  int n_checks = 0;
  int n_errors = 0;

  rst_sequencer #(.HOLD_CYCLES(4), .DEBOUNCE_CYCLES(3), .DIV(3), .BTN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .btn_i(btn), .resetn(resetn1), .ce_o(ce1)
  );

  rst_sequencer #(.HOLD_CYCLES(1), .DEBOUNCE_CYCLES(3), .DIV(1), .BTN_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .reset(reset), .btn_i(btn), .resetn(resetn2), .ce_o(ce2)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int DEB = 3;
  bit hist[$] = '{1'b1, 1'b1};   // btn samples, newest first
  bit m_db[2];
  int m_run[2];
  int m_since[2];               // edges since E0
  int m_k[2];                   // edges since resetn rose
  bit m_resetn[2];
  bit m_ce[2];

  function automatic int hold_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int div_of(input int u);
    return (u == 0) ? 3 : 1;
  endfunction

  task automatic model_step(input logic r, input logic b);
    bit syncp;
    bit old_db;
    if (r) begin
      hist = '{1'b1, 1'b1};
      for (int u = 0; u < 2; u++) begin
        m_db[u] = 0; m_run[u] = 0; m_since[u] = 0; m_k[u] = 0;
        m_resetn[u] = 0; m_ce[u] = 0;
      end
    end else begin
      syncp = !hist[1];
      hist.push_front(b);
      void'(hist.pop_back());
      for (int u = 0; u < 2; u++) begin
        old_db = m_db[u];
        if (syncp != m_db[u]) begin
          m_run[u]++;
          if (m_run[u] == DEB) begin
            m_db[u] = !m_db[u];
            m_run[u] = 0;
          end
        end else begin
          m_run[u] = 0;
        end
        if (m_db[u]) begin
          m_resetn[u] = 0; m_ce[u] = 0; m_since[u] = 0; m_k[u] = 0;
        end else if (old_db) begin
          m_resetn[u] = 0; m_ce[u] = 0; m_since[u] = 0;
        end else if (m_resetn[u]) begin
          m_k[u]++;
          m_ce[u] = (m_k[u] % div_of(u) == 0);
        end else begin
          m_since[u]++;
          m_ce[u] = 0;
          if (m_since[u] >= hold_of(u)) begin
            m_resetn[u] = 1;
            m_k[u] = 0;
          end
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic b);
    reset = r;
    btn   = b;
    @(posedge clk);
    #1;
    model_step(r, b);
    check("model_resetn",  int'(resetn1), int'(m_resetn[0]));
    check("model_ce",      int'(ce1),     int'(m_ce[0]));
    check("model_resetn2", int'(resetn2), int'(m_resetn[1]));
    check("model_ce2",     int'(ce2),     int'(m_ce[1]));
  endtask

  typedef struct {
    logic r;
    logic b;
    logic exp_resetn;
    logic exp_ce;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int lat;
    int falls;
    logic prev;
    logic btn_r;

    // Power-up: reset on edges 0..4 (E0 = edge 4); resetn rises at edge 8,
    // ce at edges 11, 14, 17.
    for (int i = 0; i < 18; i++) begin
      tbl[i].r          = (i < 5);
      tbl[i].b          = 1'b1;
      tbl[i].exp_resetn = (i >= 8);
      tbl[i].exp_ce     = (i >= 11) && ((i - 11) % 3 == 0);
    end
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].b);
      check("tbl_resetn", int'(resetn1), int'(tbl[i].exp_resetn));
      check("tbl_ce",     int'(ce1),     int'(tbl[i].exp_ce));
    end

    // Glitch rejection: 2-cycle press, cadence must continue.
    for (int j = 1; j <= 12; j++) begin
      step(1'b0, (j <= 2) ? 1'b0 : 1'b1);
      check("glitch_resetn", int'(resetn1), 1);
      check("glitch_ce",     int'(ce1),     (j % 3 == 0) ? 1 : 0);
    end

    // Manual reset: fall 5 edges after press, rise 9 edges after release.
    for (lat = 1; lat <= 30; lat++) begin
      step(1'b0, 1'b0);
      if (!resetn1) break;
    end
    check("press_latency", lat, 5);
    check("press_ce", int'(ce1), 0);
    for (int j = 0; j < 15; j++) begin
      step(1'b0, 1'b0);
      check("press_held_resetn", int'(resetn1), 0);
    end
    for (lat = 1; lat <= 30; lat++) begin
      step(1'b0, 1'b1);
      if (resetn1) break;
    end
    check("release_latency", lat, 9);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1);

    // Bouncy press: exactly one fall, 5 edges after the steady 0 begins.
    falls = 0;
    prev  = resetn1;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, (j % 2 == 0) ? 1'b0 : 1'b1);
      if (prev && !resetn1) falls++;
      prev = resetn1;
    end
    check("bounce_no_early_fall", falls, 0);
    for (lat = 1; lat <= 30; lat++) begin
      step(1'b0, 1'b0);
      if (prev && !resetn1) falls++;
      prev = resetn1;
      if (!resetn1) break;
    end
    check("bounce_latency", lat, 5);
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b0);
      if (prev && !resetn1) falls++;
      prev = resetn1;
    end
    check("bounce_falls", falls, 1);
    for (int j = 0; j < 12; j++) step(1'b0, 1'b1);
    check("bounce_recovered", int'(resetn1), 1);

    // Reset mid-run with the divider at 1.
    for (lat = 1; lat <= 10; lat++) begin
      step(1'b0, 1'b1);
      if (ce1) break;
    end
    check("midrun_ce_seen", int'(ce1), 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("midrun_resetn", int'(resetn1), 0);
    check("midrun_ce",     int'(ce1),     0);
    for (lat = 1; lat <= 30; lat++) begin
      step(1'b0, 1'b1);
      if (resetn1) break;
    end
    check("midrun_hold", lat, 4);
    for (lat = 1; lat <= 30; lat++) begin
      step(1'b0, 1'b1);
      if (ce1) break;
    end
    check("midrun_ce_phase", lat, 3);

    // DIV=1, HOLD=1 instance.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("d1_resetn_rise", int'(resetn2), 1);
    check("d1_ce_rise_edge", int'(ce2), 0);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b1);
      check("d1_ce_every", int'(ce2), 1);
    end

    // Randomised run against the model.
    btn_r = 1'b1;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 7) == 0) btn_r = ~btn_r;
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, btn_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
